// File: rtl/reflex_gate_array_if.sv
// Bus bundle for reflex_gate_array: policy/safe torque inputs, veto requests,
// release controls and the registered per-channel command/status outputs.
interface reflex_gate_array_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int LOCK_W = 16,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0]        reflex_active;
  logic                     global_reflex;
  logic [NUM_CH*DATA_W-1:0] policy_torque;
  logic [NUM_CH*DATA_W-1:0] safe_torque;
  logic [LOCK_W-1:0]        lock_duration;
  logic [DATA_W-1:0]        ramp_step;
  logic [NUM_CH*DATA_W-1:0] final_command;
  logic [NUM_CH-1:0]        override_status;
  logic [NUM_CH-1:0]        ramp_status;
  logic [NUM_CH*CNT_W-1:0]  veto_count;

  modport master (
    output reflex_active, global_reflex, policy_torque, safe_torque,
           lock_duration, ramp_step,
    input  final_command, override_status, ramp_status, veto_count
  );

  modport slave (
    input  reflex_active, global_reflex, policy_torque, safe_torque,
           lock_duration, ramp_step,
    output final_command, override_status, ramp_status, veto_count
  );
endinterface

// File: rtl/reflex_gate_array.sv
// Multi-channel reflex veto gate: PASS/LOCK/RAMP per channel with rate-limited release.
// Optional feature macro: REFLEX_GATE_VETO_CNT_EN enables saturating per-channel veto event counters.
module reflex_gate_array #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int LOCK_W = 16,
  parameter int CNT_W  = 16
) (
  input logic                clk,
  input logic                rst,
  reflex_gate_array_if.slave bus
);
  localparam logic [1:0] ST_PASS = 2'd0;
  localparam logic [1:0] ST_LOCK = 2'd1;
  localparam logic [1:0] ST_RAMP = 2'd2;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]          state_r, state_s;
    logic [LOCK_W-1:0]   lock_r, lock_s;
    logic [DATA_W-1:0]   out_r, out_s;
    logic                ovr_r, ovr_s;
    logic                ramp_r, ramp_s;
    logic                veto_s;
    logic [DATA_W-1:0]   policy_s, safe_s;
    logic signed [DATA_W:0] diff_s;
    logic [DATA_W:0]     mag_s, step_s;

    assign veto_s   = bus.reflex_active[i] | bus.global_reflex;
    assign policy_s = bus.policy_torque[i*DATA_W +: DATA_W];
    assign safe_s   = bus.safe_torque[i*DATA_W +: DATA_W];
    // Distance to policy in one extra bit so full-range swings cannot overflow.
    assign diff_s   = $signed({policy_s[DATA_W-1], policy_s}) - $signed({out_r[DATA_W-1], out_r});
    assign mag_s    = diff_s[DATA_W] ? $unsigned(-diff_s) : $unsigned(diff_s);
    assign step_s   = {1'b0, bus.ramp_step};

    // Next-state, next-output and status decode for this channel.
    always_comb begin
      state_s = state_r;
      lock_s  = lock_r;
      out_s   = out_r;
      ovr_s   = 1'b0;
      ramp_s  = 1'b0;
      case (state_r)
        ST_PASS: begin
          if (veto_s) begin
            state_s = ST_LOCK;
            lock_s  = bus.lock_duration;
            out_s   = safe_s;
            ovr_s   = 1'b1;
          end else begin
            out_s   = policy_s;
          end
        end
        ST_LOCK: begin
          out_s = safe_s;
          ovr_s = 1'b1;
          if (veto_s) begin
            lock_s = bus.lock_duration;
          end else if (lock_r != {LOCK_W{1'b0}}) begin
            lock_s = lock_r - LOCK_W'(1);
          end else if (bus.ramp_step == {DATA_W{1'b0}}) begin
            state_s = ST_PASS;
          end else begin
            state_s = ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (veto_s) begin
            state_s = ST_LOCK;
            lock_s  = bus.lock_duration;
            out_s   = safe_s;
            ovr_s   = 1'b1;
          end else if (mag_s <= step_s) begin
            state_s = ST_PASS;
            out_s   = policy_s;
          end else begin
            // |d| > step, so the modular sum lands strictly between out_r and policy.
            out_s  = diff_s[DATA_W] ? (out_r - bus.ramp_step) : (out_r + bus.ramp_step);
            ramp_s = 1'b1;
          end
        end
        default: begin
          state_s = ST_PASS;
          lock_s  = {LOCK_W{1'b0}};
          out_s   = policy_s;
        end
      endcase
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_r <= ST_PASS;
        lock_r  <= {LOCK_W{1'b0}};
        out_r   <= {DATA_W{1'b0}};
        ovr_r   <= 1'b0;
        ramp_r  <= 1'b0;
      end else begin
        state_r <= state_s;
        lock_r  <= lock_s;
        out_r   <= out_s;
        ovr_r   <= ovr_s;
        ramp_r  <= ramp_s;
      end
    end

    assign bus.final_command[i*DATA_W +: DATA_W] = out_r;
    assign bus.override_status[i]                = ovr_r;
    assign bus.ramp_status[i]                    = ramp_r;

`ifdef REFLEX_GATE_VETO_CNT_EN
    logic [CNT_W-1:0] vcnt_r;
    logic             event_s;

    // Reloads while already locked are not new events.
    assign event_s = veto_s && (state_r == ST_PASS || state_r == ST_RAMP);

    // Saturating veto event counter.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vcnt_r <= {CNT_W{1'b0}};
      end else if (event_s && (vcnt_r != {CNT_W{1'b1}})) begin
        vcnt_r <= vcnt_r + CNT_W'(1);
      end else begin
        vcnt_r <= vcnt_r;
      end
    end

    assign bus.veto_count[i*CNT_W +: CNT_W] = vcnt_r;
`else
    assign bus.veto_count[i*CNT_W +: CNT_W] = {CNT_W{1'b0}};
`endif
  end
endmodule

// File: tb/tb_reflex_gate_array.sv
// Directed self-checking bench for reflex_gate_array (4 channels, 16-bit data, 2-bit veto counters).
module tb_reflex_gate_array;
  logic clk;
  logic rst;

`ifdef REFLEX_GATE_VETO_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  reflex_gate_array_if #(.NUM_CH(4), .DATA_W(16), .LOCK_W(16), .CNT_W(2)) bus ();

  reflex_gate_array #(.NUM_CH(4), .DATA_W(16), .LOCK_W(16), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] cmd(input int ch);
    return $signed(bus.final_command[ch*16 +: 16]);
  endfunction

  function automatic logic signed [31:0] vexp(input int v);
    return CNT_EN ? 32'(v) : 32'sd0;
  endfunction

  task automatic pol(input int ch, input int v);
    bus.policy_torque[ch*16 +: 16] = 16'(v);
  endtask

  task automatic saf(input int ch, input int v);
    bus.safe_torque[ch*16 +: 16] = 16'(v);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int c = 0; c < 4; c++) chk({tag, "_cmd"}, 32'(cmd(c)), 32'sd0);
    chk({tag, "_ovr"}, 32'(bus.override_status), 32'sd0);
    chk({tag, "_ramp"}, 32'(bus.ramp_status), 32'sd0);
    chk({tag, "_vcnt"}, 32'(bus.veto_count), 32'sd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.reflex_active = 4'b0000;
    bus.global_reflex = 1'b0;
    bus.policy_torque = 64'd0;
    bus.safe_torque   = 64'd0;
    bus.lock_duration = 16'd0;
    bus.ramp_step     = 16'd0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // Pass-through
    pol(0, 1000); pol(1, 500); pol(2, 250); pol(3, -7);
    tick();
    chk("pass_ch0", 32'(cmd(0)), 1000);
    chk("pass_ch3", 32'(cmd(3)), -7);
    chk("pass_ovr", 32'(bus.override_status), 0);
    chk("pass_ramp", 32'(bus.ramp_status), 0);

    // Lock/hold on ch1: N=3 gives 5 safe cycles
    bus.lock_duration = 16'd3;
    bus.reflex_active = 4'b0010;
    tick();
    chk("lock_ch1", 32'(cmd(1)), 0);
    chk("lock_ovr", 32'(bus.override_status), 2);
    chk("lock_ch0_unaff", 32'(cmd(0)), 1000);
    bus.reflex_active = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("hold_ch1", 32'(cmd(1)), 0);
      chk("hold_ovr", 32'(bus.override_status), 2);
    end
    tick();
    chk("release_ch1", 32'(cmd(1)), 500);
    chk("release_ovr", 32'(bus.override_status), 0);
    chk("vcnt_lock", 32'(bus.veto_count), vexp(4));

    // Ramp release on ch2, positive then negative
    bus.lock_duration = 16'd0;
    bus.ramp_step     = 16'd100;
    bus.reflex_active = 4'b0100;
    tick();
    chk("ramp_lock", 32'(cmd(2)), 0);
    chk("ramp_lock_ovr", 32'(bus.override_status), 4);
    bus.reflex_active = 4'b0000;
    tick();
    chk("ramp_zero", 32'(cmd(2)), 0);
    chk("ramp_zero_ovr", 32'(bus.override_status), 4);
    chk("ramp_zero_rs", 32'(bus.ramp_status), 0);
    tick();
    chk("ramp_100", 32'(cmd(2)), 100);
    chk("ramp_100_rs", 32'(bus.ramp_status), 4);
    chk("ramp_100_ovr", 32'(bus.override_status), 0);
    tick();
    chk("ramp_200", 32'(cmd(2)), 200);
    chk("ramp_200_rs", 32'(bus.ramp_status), 4);
    tick();
    chk("ramp_250", 32'(cmd(2)), 250);
    chk("ramp_250_rs", 32'(bus.ramp_status), 0);

    pol(2, -250);
    bus.reflex_active = 4'b0100;
    tick();
    chk("nramp_lock", 32'(cmd(2)), 0);
    bus.reflex_active = 4'b0000;
    tick();
    chk("nramp_zero", 32'(cmd(2)), 0);
    tick();
    chk("nramp_m100", 32'(cmd(2)), -100);
    tick();
    chk("nramp_m200", 32'(cmd(2)), -200);
    tick();
    chk("nramp_m250", 32'(cmd(2)), -250);
    chk("nramp_rs", 32'(bus.ramp_status), 0);
    chk("vcnt_ramp", 32'(bus.veto_count), vexp(36));

    // Re-veto mid-ramp on ch3 with a held veto
    pol(3, 300);
    bus.reflex_active = 4'b1000;
    tick();
    chk("rv_lock", 32'(cmd(3)), 0);
    bus.reflex_active = 4'b0000;
    tick();
    tick();
    chk("rv_ramp100", 32'(cmd(3)), 100);
    chk("rv_ramp_rs", 32'(bus.ramp_status), 8);
    bus.reflex_active = 4'b1000;
    tick();
    chk("rv_safe", 32'(cmd(3)), 0);
    chk("rv_ovr", 32'(bus.override_status), 8);
    chk("rv_rs", 32'(bus.ramp_status), 0);
    chk("rv_vcnt", 32'(bus.veto_count), vexp(164));
    tick();
    tick();
    chk("rv_held_safe", 32'(cmd(3)), 0);
    chk("rv_held_vcnt", 32'(bus.veto_count), vexp(164));
    bus.reflex_active = 4'b0000;
    tick();
    chk("rv_exit", 32'(cmd(3)), 0);
    tick();
    tick();
    tick();
    chk("rv_done", 32'(cmd(3)), 300);

    // Global reflex: every channel locks on the same edge
    saf(0, 11); saf(1, 22); saf(2, 33); saf(3, -44);
    bus.global_reflex = 1'b1;
    tick();
    chk("glob_ovr", 32'(bus.override_status), 15);
    chk("glob_ch0", 32'(cmd(0)), 11);
    chk("glob_ch1", 32'(cmd(1)), 22);
    chk("glob_ch2", 32'(cmd(2)), 33);
    chk("glob_ch3", 32'(cmd(3)), -44);
    chk("glob_vcnt", 32'(bus.veto_count), vexp(249));
    bus.global_reflex = 1'b0;
    bus.ramp_step     = 16'd0;
    tick();
    chk("glob_exit_ch3", 32'(cmd(3)), -44);
    tick();
    chk("glob_back_ch0", 32'(cmd(0)), 1000);
    chk("glob_back_ch3", 32'(cmd(3)), 300);
    chk("glob_back_ovr", 32'(bus.override_status), 0);

    // Counter saturation: ch0 reaches 5 events total
    for (int n = 0; n < 4; n++) begin
      bus.reflex_active = 4'b0001;
      tick();
      bus.reflex_active = 4'b0000;
      tick();
    end
    chk("vcnt_sat", 32'(bus.veto_count), vexp(251));

    // Full-range single-step release
    bus.ramp_step = 16'hFFFF;
    saf(2, -32768);
    pol(2, 32767);
    bus.reflex_active = 4'b0100;
    tick();
    chk("bnd_lock", 32'(cmd(2)), -32768);
    bus.reflex_active = 4'b0000;
    tick();
    chk("bnd_exit", 32'(cmd(2)), -32768);
    chk("bnd_exit_ovr", 32'(bus.override_status), 4);
    tick();
    chk("bnd_release", 32'(cmd(2)), 32767);
    chk("bnd_rs", 32'(bus.ramp_status), 0);
    chk("bnd_ovr", 32'(bus.override_status), 0);

    // Asynchronous reset mid-lock
    bus.lock_duration = 16'd10;
    bus.reflex_active = 4'b0010;
    tick();
    chk("ml_ovr", 32'(bus.override_status), 2);
    bus.reflex_active = 4'b0000;
    tick();
    chk("ml_safe", 32'(cmd(1)), 22);
    rst = 1'b1;
    #1;
    chk_all_zero("midlock_rst");
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ch1", 32'(cmd(1)), 500);
    chk("post_rst_ovr", 32'(bus.override_status), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reflex_gate_array.md
# reflex_gate_array

Multi-channel, parametrised successor to the single-channel reflex veto gate. Sits between the AI policy torque outputs and the motor drivers: each channel passes its policy torque through unless its SNN reflex (or the global reflex) vetoes it. Vetoed channels hold a per-channel safe torque for a programmable lock time. They then slew back to the policy value at a bounded rate instead of stepping.

## Interface
- NUM_CH, 4, number of independent actuator channels (1..16)
- DATA_W, 16, signed torque width
- LOCK_W, 16, lock counter width
- CNT_W, 16, per-channel veto event counter width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- reflex_active  in  NUM_CH  per-channel veto request, bit i = channel i
- global_reflex  in  1  veto all channels simultaneously
- policy_torque  in  NUM_CH*DATA_W  packed signed requests, channel i at [i*DATA_W +: DATA_W]
- safe_torque  in  NUM_CH*DATA_W  packed signed per-channel safe values
- lock_duration  in  LOCK_W  extra hold cycles after veto drops (shared)
- ramp_step  in  DATA_W  unsigned max change per cycle during release; 0 = instant release
- final_command  out  NUM_CH*DATA_W  packed signed motor commands
- override_status  out  NUM_CH  channel is in LOCK
- ramp_status  out  NUM_CH  channel is in RAMP
- veto_count  out  NUM_CH*CNT_W  packed saturating veto event counters

## Operation
- Channels are fully independent, except for the shared global_reflex, lock_duration and ramp_step.
- Effective veto: v_i = reflex_active[i] | global_reflex.
- Per-channel FSM states: PASS, LOCK, RAMP. Reset state: PASS.
- PASS:
  - v_i=1 -> LOCK, load counter with lock_duration.
  - Otherwise stay; output = policy_i.
- LOCK:
  - Output = safe_i.
  - v_i=1 -> reload counter with lock_duration.
  - Else counter>0 -> decrement.
  - Else counter=0 -> RAMP, or PASS directly if ramp_step=0.
- RAMP:
  - v_i=1 -> LOCK with reload; this takes priority over everything.
  - Otherwise d = policy_i - prev_out, computed signed in DATA_W+1 bits.
  - If |d| <= ramp_step: output = policy_i and go to PASS.
  - Else: output = prev_out ± ramp_step toward policy_i; stay in RAMP.
  - Tracks the current policy_i every cycle.
  - ramp_step is treated as unsigned; the step result never overshoots policy_i and never leaves the DATA_W signed range.
- A new veto event is any PASS->LOCK or RAMP->LOCK transition. A reload while already in LOCK is not an event.

## Timing
- All outputs registered; latency 1 cycle.
  - The output after edge k reflects the inputs sampled at edge k and the next state.
- Veto sampled at edge k -> final_command_i = safe_i and override_status[i]=1 from edge k.
- Single-cycle veto at edge k, lock_duration=N:
  - LOCK output at edges k..k+N+1, i.e. N+2 cycles; the counter-zero cycle is included.
  - First RAMP (or PASS) output at edge k+N+2.
- Veto held continuously: LOCK persists; release timing counts from the last asserted edge.
- Changing safe_i or policy_i during LOCK takes effect at the next edge.
- lock_duration is sampled only at load/reload.
- Reset (any time, mid-lock or mid-ramp):
  - final_command=0, override_status=0, ramp_status=0, veto_count=0.
  - All counters 0; all FSMs to PASS.

## Configuration
- REFLEX_GATE_VETO_CNT_EN defined: veto_count[i] increments by 1 on each new veto event and saturates at 2^CNT_W-1 without wrapping.
- Undefined: counter logic omitted; the veto_count port remains and is driven constant 0.

## Test plan
- Pass-through: no veto, ch0 policy=1000 -> final ch0=1000 one cycle later; override_status=0, ramp_status=0.
- Lock/hold: ch1 reflex pulse one cycle, lock_duration=3, safe=0, policy=500, ramp_step=0 -> ch1 outputs 0 for 5 cycles, then 500; other channels unaffected.
- Ramp release:
  - Stimulus: ch2 lock_duration=0, safe=0, policy=250, ramp_step=100, one-cycle veto.
  - Response: outputs 0, 0, 100, 200, 250; ramp_status high on the 100 and 200 cycles.
  - Negative direction: policy=-250 gives -100, -200, -250.
- Re-veto mid-ramp:
  - Veto during RAMP -> immediate safe output, override_status=1.
  - With the macro defined, veto_count increments on the RAMP->LOCK entry; the held veto itself adds only one event.
  - Global reflex -> all NUM_CH channels enter LOCK on the same edge.
- Boundaries:
  - Stimulus: safe=-32768, policy=32767, ramp_step=65535.
  - Response: single-step release to 32767 with no overflow.
  - Counter: with CNT_W=2 and 5 events, veto_count saturates at 3.
  - Reset mid-lock: all outputs 0 and state PASS.
